// File: rtl/program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Bus initiator that copies a byte stream into Memory before the
//               CPU runs. Holds the CPU in reset while loading. Each accepted
//               byte becomes one write at LOAD_BASE+index (mod 2**ADDR_W).
//               Optional build macro LOADER_VERIFY_EN adds a read-back check
//               after every write; a mismatch parks the loader in ERROR.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] adr_bus,
    output logic [DATA_W-1:0] data_bus_out,
    input  logic [DATA_W-1:0] data_bus_in,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] c_BASE = (ADDR_W)'(LOAD_BASE);
    localparam logic [ADDR_W:0]   c_LEN  = (ADDR_W+1)'(LOAD_LEN);
    localparam logic [ADDR_W:0]   c_LAST = (ADDR_W+1)'(LOAD_LEN - 1);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_WAIT_BYTE  = 3'd1;
    localparam logic [2:0] c_WRITE      = 3'd2;
`ifdef LOADER_VERIFY_EN
    localparam logic [2:0] c_VERIFY_RD  = 3'd3;
    localparam logic [2:0] c_VERIFY_CHK = 3'd4;
`endif
    localparam logic [2:0] c_DONE       = 3'd5;
    localparam logic [2:0] c_ERROR      = 3'd6;

    // ------------------------------------------------------------------
    // State and datapath
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [DATA_W-1:0] r_byte;
    logic [ADDR_W-1:0] r_adr;
    logic [ADDR_W:0]   r_count;
    logic              w_start_ok;
    logic              w_accept;

    // start is only honoured from the resting states
    assign w_start_ok = start && ((r_state == c_IDLE) || (r_state == c_DONE) ||
                                  (r_state == c_ERROR));
    // in_ready is asserted exactly in WAIT_BYTE, so this is the handshake
    assign w_accept   = in_valid && (r_state == c_WAIT_BYTE);

`ifndef LOADER_VERIFY_EN
    // Read-back data is meaningless without the verify stage
    logic w_unused_din;
    assign w_unused_din = ^data_bus_in;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE, c_DONE, c_ERROR: begin
                if (start) w_state_nxt = c_WAIT_BYTE;
            end
            c_WAIT_BYTE: begin
                if (in_valid) w_state_nxt = c_WRITE;
            end
            c_WRITE: begin
`ifdef LOADER_VERIFY_EN
                w_state_nxt = c_VERIFY_RD;
`else
                w_state_nxt = (r_count == c_LAST) ? c_DONE : c_WAIT_BYTE;
`endif
            end
`ifdef LOADER_VERIFY_EN
            c_VERIFY_RD: begin
                w_state_nxt = c_VERIFY_CHK;
            end
            c_VERIFY_CHK: begin
                // r_count already includes the byte under test
                if (data_bus_in != r_byte) begin
                    w_state_nxt = c_ERROR;
                end else if (r_count == c_LEN) begin
                    w_state_nxt = c_DONE;
                end else begin
                    w_state_nxt = c_WAIT_BYTE;
                end
            end
`endif
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Byte latch, target address and count; address is frozen at accept
    // time so the verify read reuses it after the count has advanced
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte  <= '0;
            r_adr   <= '0;
            r_count <= '0;
        end else begin
            if (w_start_ok) begin
                r_count <= '0;
            end
            if (w_accept) begin
                r_byte <= in_data;
                r_adr  <= c_BASE + r_count[ADDR_W-1:0];
            end
            if (r_state == c_WRITE) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign byte_count = r_count;

    // Output decode, purely from state so strobes drop with async reset
    always_comb begin
        in_ready     = 1'b0;
        wr_mem       = 1'b0;
        rd_mem       = 1'b0;
        adr_bus      = '0;
        data_bus_out = '0;
        busy         = 1'b0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            c_WAIT_BYTE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            c_WRITE: begin
                wr_mem       = 1'b1;
                adr_bus      = r_adr;
                data_bus_out = r_byte;
                busy         = 1'b1;
                cpu_hold     = 1'b1;
            end
`ifdef LOADER_VERIFY_EN
            c_VERIFY_RD: begin
                rd_mem   = 1'b1;
                adr_bus  = r_adr;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            c_VERIFY_CHK: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            c_ERROR: begin
                err      = 1'b1;
                cpu_hold = 1'b1;
            end
`else
            c_ERROR: begin
                cpu_hold = 1'b1;
            end
`endif
            c_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Two loaders (base 0
//               and base 62, 4-byte loads) share one random byte stream; a
//               scoreboard predicts every write address/data from the image
//               and index, and a memory model backs each loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int c_LEN   = 4;
    localparam int c_BASE1 = 62;
`ifdef LOADER_VERIFY_EN
    localparam int c_GAP   = 4;
`else
    localparam int c_GAP   = 2;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       in_ready [2];
    logic       rd_mem   [2];
    logic       wr_mem   [2];
    logic       cpu_hold [2];
    logic       busy     [2];
    logic       done     [2];
    logic       err      [2];
    logic [5:0] adr      [2];
    logic [7:0] dout     [2];
    logic [7:0] din      [2];
    logic [6:0] bcount   [2];

    logic [7:0] mem [2][64];
    logic [7:0] image [c_LEN];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  load_id = 0;
    int  exp_limit = c_LEN;
    bit  b2b = 1'b0;
    bit  corrupt = 1'b0;

    int  widx     [2] = '{0, 0};
    int  mon_id   [2] = '{0, 0};
    int  last_cyc [2] = '{0, 0};
    int  last_adr [2] = '{0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        program_loader #(
            .ADDR_W   (6),
            .DATA_W   (8),
            .LOAD_BASE((g == 0) ? 0 : c_BASE1),
            .LOAD_LEN (c_LEN)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start),
            .in_data     (in_data),
            .in_valid    (in_valid),
            .in_ready    (in_ready[g]),
            .adr_bus     (adr[g]),
            .data_bus_out(dout[g]),
            .data_bus_in (din[g]),
            .rd_mem      (rd_mem[g]),
            .wr_mem      (wr_mem[g]),
            .cpu_hold    (cpu_hold[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .err         (err[g]),
            .byte_count  (bcount[g])
        );
    end

    function automatic int base_of(input int i);
        return (i == 0) ? 0 : c_BASE1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory model: synchronous write, registered read; optional corruption
    // of the second image location on read-back
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (wr_mem[i]) mem[i][adr[i]] <= dout[i];
            if (rd_mem[i]) begin
                din[i] <= mem[i][adr[i]] ^
                    ((corrupt && (int'(adr[i]) == (base_of(i) + 1) % 64)) ? 8'hFF : 8'h00);
            end
        end
    end

    // Scoreboard: every write must be the next image byte at base+index
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_id[i] != load_id) begin
                mon_id[i] = load_id;
                widx[i]   = 0;
            end
            if (wr_mem[i]) begin
                check("wr_extra", 32'(widx[i] < exp_limit), 1);
                check("wr_adr", 32'(adr[i]), 32'((base_of(i) + widx[i]) % 64));
                if (widx[i] < c_LEN) check("wr_dat", 32'(dout[i]), 32'(image[widx[i]]));
                check("wr_rdy", 32'(in_ready[i]), 0);
                check("wr_rd", 32'(rd_mem[i]), 0);
                if (b2b && widx[i] > 0) check("wr_gap", 32'(cyc - last_cyc[i]), c_GAP);
                last_cyc[i] = cyc;
                last_adr[i] = int'(adr[i]);
                widx[i]++;
            end
`ifdef LOADER_VERIFY_EN
            if (rd_mem[i]) begin
                check("rd_adr", 32'(adr[i]), 32'(last_adr[i]));
                check("rd_dout", 32'(dout[i]), 0);
            end
`endif
        end
    end

    task automatic check_quiet(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_wr"},   32'(wr_mem[i]), 0);
            check({tag, "_rd"},   32'(rd_mem[i]), 0);
            check({tag, "_rdy"},  32'(in_ready[i]), 0);
            check({tag, "_hold"}, 32'(cpu_hold[i]), 0);
            check({tag, "_busy"}, 32'(busy[i]), 0);
            check({tag, "_done"}, 32'(done[i]), 0);
            check({tag, "_err"},  32'(err[i]), 0);
            check({tag, "_adr"},  32'(adr[i]), 0);
            check({tag, "_dout"}, 32'(dout[i]), 0);
            check({tag, "_cnt"},  32'(bcount[i]), 0);
        end
    endtask

    task automatic start_pulse();
        load_id++;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("st_cnt",  32'(bcount[i]), 0);
            check("st_busy", 32'(busy[i]), 1);
            check("st_hold", 32'(cpu_hold[i]), 1);
            check("st_done", 32'(done[i]), 0);
            check("st_err",  32'(err[i]), 0);
            check("st_rdy",  32'(in_ready[i]), 1);
        end
    endtask

    // Present one byte after a random idle gap; hold it until accepted
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int n;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        n = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hs_timeout", 32'(n < 50), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_flag(input string tag, input bit want_err);
        int n;
        n = 0;
        while (!(want_err ? (err[0] && err[1]) : (done[0] && done[1])) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 60), 1);
    endtask

    task automatic do_load(input int max_gap);
        exp_limit = c_LEN;
        start_pulse();
        for (int k = 0; k < c_LEN; k++) send_byte(image[k], max_gap);
        wait_flag("done_to", 1'b0);
        for (int i = 0; i < 2; i++) begin
            check("end_done", 32'(done[i]), 1);
            check("end_hold", 32'(cpu_hold[i]), 0);
            check("end_busy", 32'(busy[i]), 0);
            check("end_rdy",  32'(in_ready[i]), 0);
            check("end_cnt",  32'(bcount[i]), c_LEN);
            check("end_nwr",  32'(widx[i]), c_LEN);
        end
        for (int k = 0; k < c_LEN; k++) begin
            check("mem0", 32'(mem[0][k]), 32'(image[k]));
            check("mem1", 32'(mem[1][(c_BASE1 + k) % 64]), 32'(image[k]));
        end
    endtask

    task automatic random_image();
        for (int k = 0; k < c_LEN; k++) image[k] = 8'($urandom);
    endtask

    initial begin
        int nb;
        // Reset state
        repeat (3) @(negedge clk);
        check_quiet("rst");
        reset = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        // Fixed image, back-to-back stream
        image[0] = 8'hA5; image[1] = 8'h5A; image[2] = 8'hFF; image[3] = 8'h00;
        b2b = 1'b1;
        do_load(0);
        b2b = 1'b0;

        // Random images with random valid gaps
        repeat (4) begin
            random_image();
            do_load(4);
        end

        // Stream keeps offering after DONE: nothing must be consumed
        in_valid = 1'b1;
        in_data  = 8'h3C;
        repeat (6) @(negedge clk);
        check("post_rdy", 32'(in_ready[0]), 0);
        in_valid = 1'b0;

        // Asynchronous reset at a random point inside a load
        repeat (3) begin
            random_image();
            exp_limit = c_LEN;
            start_pulse();
            nb = int'($urandom_range(0, c_LEN - 1));
            for (int k = 0; k < nb; k++) send_byte(image[k], 2);
            repeat ($urandom_range(0, 1)) @(negedge clk);
            #2 reset = 1'b0;
            #1 check_quiet("async");
            in_valid = 1'b0;
            @(negedge clk) reset = 1'b1;
            @(negedge clk);
            check_quiet("rel");
        end

        // Reset during the second write, then a fresh load
        random_image();
        exp_limit = c_LEN;
        start_pulse();
        send_byte(image[0], 0);
        send_byte(image[1], 0);
        check("w2_seen", 32'(wr_mem[0]), 1);
        #2 reset = 1'b0;
        #1 check_quiet("midwr");
        @(negedge clk) reset = 1'b1;
        random_image();
        do_load(1);

`ifdef LOADER_VERIFY_EN
        // Read-back mismatch on the second byte
        random_image();
        corrupt   = 1'b1;
        exp_limit = 2;
        start_pulse();
        send_byte(image[0], 0);
        send_byte(image[1], 0);
        wait_flag("err_to", 1'b1);
        in_valid = 1'b1;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("e_err",  32'(err[i]), 1);
            check("e_hold", 32'(cpu_hold[i]), 1);
            check("e_busy", 32'(busy[i]), 0);
            check("e_done", 32'(done[i]), 0);
            check("e_rdy",  32'(in_ready[i]), 0);
            check("e_cnt",  32'(bcount[i]), 2);
            check("e_nwr",  32'(widx[i]), 2);
        end
        corrupt = 1'b0;
        random_image();
        do_load(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
